// File: rtl/toeplitz_pkg.sv
// Shared parameters and state encoding for the Toeplitz seed shifter / hash accumulator pair.
package toeplitz_pkg;

  localparam int ROW_W_DEF    = 3072;
  localparam int NUM_ROWS_DEF = 4096;
  localparam int CNT_W_DEF    = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/toeplitz_xor_acc.sv
// GF(2) row accumulator: XORs a Toeplitz row into the running hash when its raw bit is set.
module toeplitz_xor_acc #(
  parameter int ROW_W = 8
) (
  input  logic             clk_in,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [ROW_W-1:0] acc_q
);

  logic [ROW_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i && bit_i)
      acc_d = acc_q ^ row_i;
  end

  always_ff @(posedge clk_in)
    acc_q <= acc_d;

endmodule

// File: rtl/toeplitz_hash_accum.sv
// Consumer of the Toeplitz row stream: takes a raw block, requests rows, accumulates
// the GF(2) matrix-vector product and hands the hash to a valid/ready sink.
module toeplitz_hash_accum
  import toeplitz_pkg::*;
#(
  parameter int ROW_W    = ROW_W_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] raw_data,
  input  logic                raw_valid,
  output logic                raw_ready,
  output logic                shift_en,
  input  logic                seed_ack,
  input  logic                sum_en,
  input  logic [ROW_W-1:0]    shift_row,
  output logic [ROW_W-1:0]    hash_out,
  output logic                hash_valid,
  input  logic                hash_ready,
  output logic                row_err
);

  state_t              state_q;
  logic [NUM_ROWS-1:0] raw_sr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                shift_en_q;
  logic                hash_valid_q;
  logic                row_err_q;
  logic [ROW_W-1:0]    hash_q;
  logic [ROW_W-1:0]    acc_q;

  logic             take_raw;
  logic             row_in;
  logic             last_row;
  logic             short_blk;
  logic             raw_bit;
  logic             acc_clr;
  logic [ROW_W-1:0] acc_d;

  assign raw_ready = (state_q == IDLE);
  assign take_raw  = raw_valid & raw_ready;
  assign row_in    = (state_q == ACC) & sum_en;
  assign last_row  = row_in & (cnt_q == CNT_W'(NUM_ROWS - 1));
  assign short_blk = (state_q == ACC) & ~sum_en & (cnt_q != '0);
  assign raw_bit   = raw_sr_q[NUM_ROWS-1];
  // Value the accumulator takes on this edge; needed so the last row lands in hash_out.
  assign acc_d     = acc_q ^ (shift_row & {ROW_W{raw_bit}});
  assign acc_clr   = rst | take_raw | short_blk;

  toeplitz_xor_acc #(
    .ROW_W (ROW_W)
  ) u_acc (
    .clk_in (clk_in),
    .clr_i  (acc_clr),
    .en_i   (row_in),
    .bit_i  (raw_bit),
    .row_i  (shift_row),
    .acc_q  (acc_q)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_en_q   <= 1'b0;
      hash_valid_q <= 1'b0;
      hash_q       <= '0;
      row_err_q    <= 1'b0;
      cnt_q        <= '0;
      raw_sr_q     <= '0;
    end else begin
      row_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sum_en)
            row_err_q <= 1'b1;
          if (take_raw) begin
            raw_sr_q   <= raw_data;
            cnt_q      <= '0;
            shift_en_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (sum_en)
            row_err_q <= 1'b1;
          // Drop the request as soon as the shifter commits so it does not restart.
          if (seed_ack) begin
            shift_en_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        ACC: begin
          if (sum_en) begin
            raw_sr_q <= raw_sr_q << 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last_row) begin
              hash_q       <= acc_d;
              hash_valid_q <= 1'b1;
              state_q      <= DONE;
            end
          end else if (short_blk) begin
            row_err_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
        DONE: begin
          if (sum_en)
            row_err_q <= 1'b1;
          if (hash_ready) begin
            hash_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shift_en   = shift_en_q;
  assign hash_out   = hash_q;
  assign hash_valid = hash_valid_q;
  assign row_err    = row_err_q;

endmodule

// File: tb/tb_toeplitz_hash_accum.sv
// Directed bench for toeplitz_hash_accum at ROW_W=8, NUM_ROWS=16 with hand-computed hashes.
module tb_toeplitz_hash_accum;

  logic        clk_in;
  logic        rst;
  logic [15:0] raw_data;
  logic        raw_valid;
  logic        raw_ready;
  logic        shift_en;
  logic        seed_ack;
  logic        sum_en;
  logic [7:0]  shift_row;
  logic [7:0]  hash_out;
  logic        hash_valid;
  logic        hash_ready;
  logic        row_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int e0;

  toeplitz_hash_accum #(
    .ROW_W    (8),
    .NUM_ROWS (16),
    .CNT_W    (5)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .raw_data   (raw_data),
    .raw_valid  (raw_valid),
    .raw_ready  (raw_ready),
    .shift_en   (shift_en),
    .seed_ack   (seed_ack),
    .sum_en     (sum_en),
    .shift_row  (shift_row),
    .hash_out   (hash_out),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .row_err    (row_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in)
    if (row_err === 1'b1)
      err_pulses++;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: A5 / FF.. / 3C, mode 1: walking one, mode 2: 8'h11*k, mode 3: all ones
  function automatic logic [7:0] row_val(input int mode, input int k);
    logic [7:0] r;
    case (mode)
      0:       r = (k == 0) ? 8'hA5 : (k == 15) ? 8'h3C : 8'hFF;
      1:       r = 8'h01 << (k % 8);
      2:       r = 8'(8'h11 * k);
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  // Shifter model: acknowledge one cycle after shift_en is seen.
  task automatic seed_handshake();
    check("shift_en_rise", shift_en, 1);
    check("raw_ready_busy", raw_ready, 0);
    tick();
    check("shift_en_hold", shift_en, 1);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    check("shift_en_drop", shift_en, 0);
  endtask

  task automatic begin_block(input logic [15:0] raw);
    raw_data  = raw;
    raw_valid = 1'b1;
    for (int i = 0; i < 20 && raw_ready !== 1'b1; i++)
      tick();
    check("raw_ready_wait", raw_ready, 1);
    tick();
    raw_valid = 1'b0;
    seed_handshake();
  endtask

  task automatic feed_rows(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      sum_en    = 1'b1;
      shift_row = row_val(mode, k);
      check("no_early_valid", hash_valid, 0);
      tick();
    end
    sum_en    = 1'b0;
    shift_row = 8'h00;
  endtask

  task automatic finish_block(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, hash_valid, 1);
    check({tag, "_hash"}, hash_out, exp);
    $display("block %s hash_out=%02h expected=%02h", tag, hash_out, exp);
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    check({tag, "_valid_clr"}, hash_valid, 0);
    check({tag, "_idle"}, raw_ready, 1);
    check({tag, "_hash_keep"}, hash_out, exp);
  endtask

  initial begin
    rst        = 1'b1;
    raw_data   = 16'h0000;
    raw_valid  = 1'b0;
    seed_ack   = 1'b0;
    sum_en     = 1'b0;
    shift_row  = 8'h00;
    hash_ready = 1'b0;
    tick();
    tick();
    check("rst_raw_ready", raw_ready, 1);
    check("rst_shift_en", shift_en, 0);
    check("rst_hash_valid", hash_valid, 0);
    check("rst_hash_out", hash_out, 0);
    check("rst_row_err", row_err, 0);
    rst = 1'b0;
    tick();

    // A5 ^ 3C = 99; valid exactly 17 cycles after the seed_ack cycle
    e0 = err_pulses;
    begin_block(16'h8001);
    feed_rows(16, 0);
    finish_block("b8001", 8'h99);
    check("b8001_no_err", err_pulses - e0, 0);

    begin_block(16'hFFFF);
    feed_rows(16, 1);
    finish_block("bFFFF", 8'h00);

    begin_block(16'h0000);
    feed_rows(16, 3);
    finish_block("b0000", 8'h00);

    // Backpressure: rows 14,15 of 8'h11*k -> EE ^ FF = 11
    begin_block(16'h0003);
    feed_rows(16, 2);
    raw_data  = 16'h2000;
    raw_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", hash_valid, 1);
      check("bp_hash", hash_out, 8'h11);
      check("bp_raw_ready", raw_ready, 0);
      check("bp_shift_en", shift_en, 0);
      tick();
    end
    $display("block bp hash_out=%02h expected=11", hash_out);
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    check("bp_valid_clr", hash_valid, 0);
    check("bp_idle", raw_ready, 1);
    check("bp_not_taken", shift_en, 0);
    tick();
    raw_valid = 1'b0;
    seed_handshake();
    feed_rows(16, 2);
    finish_block("b2000", 8'h22);

    // Short block after 7 rows
    e0 = err_pulses;
    begin_block(16'hFFFF);
    feed_rows(7, 3);
    check("short_pre_err", row_err, 0);
    tick();
    check("short_err", row_err, 1);
    check("short_idle", raw_ready, 1);
    check("short_no_valid", hash_valid, 0);
    check("short_shift_en", shift_en, 0);
    tick();
    check("short_err_clr", row_err, 0);
    check("short_no_valid2", hash_valid, 0);
    check("short_one_pulse", err_pulses - e0, 1);
    $display("block short row_err_pulses=%0d expected=1", err_pulses - e0);

    // Stray sum_en and seed_ack in IDLE
    sum_en    = 1'b1;
    shift_row = 8'hFF;
    tick();
    sum_en    = 1'b0;
    shift_row = 8'h00;
    check("stray_sum_err", row_err, 1);
    check("stray_sum_idle", raw_ready, 1);
    check("stray_sum_shift", shift_en, 0);
    seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    check("stray_ack_no_err", row_err, 0);
    check("stray_ack_shift", shift_en, 0);
    check("stray_ack_idle", raw_ready, 1);
    tick();
    check("stray_idle_hold", raw_ready, 1);
    check("stray_no_valid", hash_valid, 0);
    $display("block stray row_err_on_sum=1 shift_en=%0b", shift_en);

    // Reset at row 9 leaves acc=FF; must not leak into the next block
    begin_block(16'hFFFF);
    feed_rows(9, 3);
    sum_en    = 1'b1;
    shift_row = 8'hFF;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    sum_en    = 1'b0;
    shift_row = 8'h00;
    check("mrst_shift_en", shift_en, 0);
    check("mrst_valid", hash_valid, 0);
    check("mrst_idle", raw_ready, 1);
    check("mrst_row_err", row_err, 0);
    check("mrst_hash_out", hash_out, 0);
    $display("block midreset shift_en=%0b raw_ready=%0b", shift_en, raw_ready);

    // rows 1 and 14 of 8'h11*k -> 11 ^ EE = FF
    e0 = err_pulses;
    begin_block(16'h4002);
    feed_rows(16, 2);
    finish_block("b4002", 8'hFF);
    check("b4002_no_err", err_pulses - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toeplitz_hash_accum.md
Name: toeplitz_hash_accum

Overview:
Consumer end of the Toeplitz row-stream interface that the seed shifter produces. It accepts one raw key block and requests a row stream with shift_en. It consumes one matrix row per sum_en cycle, one raw bit per row, and accumulates the GF(2) product acc ^= row & {ROW_W{raw_bit}}. It then presents the ROW_W-bit hash to the downstream sink with a valid/ready handshake.

Parameters:
ROW_W, 3072, width of each shift_row and of the hash output
NUM_ROWS, 4096, rows per block; also raw block width in bits
CNT_W, 13, row counter width; must hold NUM_ROWS (clog2(NUM_ROWS)+1)

Ports:
clk_in  input  1  clock
rst  input  1  synchronous, active-high reset
raw_data  input  NUM_ROWS  raw key block; bit NUM_ROWS-1 is consumed first
raw_valid  input  1  raw_data valid
raw_ready  output  1  block accepted when raw_valid & raw_ready
shift_en  output  1  row-stream request to the seed shifter
seed_ack  input  1  one-cycle pulse from the shifter: seed captured, rows follow
sum_en  input  1  shift_row is valid this cycle
shift_row  input  ROW_W  current Toeplitz row
hash_out  output  ROW_W  accumulated hash; stable while hash_valid
hash_valid  output  1  hash available
hash_ready  input  1  sink accepts the hash
row_err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset, clk_in edge with rst=1: state=IDLE, shift_en=0, hash_valid=0, hash_out=0, row_err=0, acc=0, cnt=0, raw_sr=0. Reset mid-block discards all work. No partial hash is emitted.
- States, 2-bit: IDLE, REQ, ACC, DONE.
- raw_ready = (state==IDLE), combinational. All other outputs are registered.
- IDLE:
  - On raw_valid & raw_ready: raw_sr<=raw_data, acc<=0, cnt<=0, shift_en<=1, go to REQ.
- REQ:
  - shift_en stays high until seed_ack=1.
  - On seed_ack: shift_en<=0 on the same edge, go to ACC. shift_en must drop so the shifter does not restart after its block.
- ACC, each cycle with sum_en=1:
  - acc <= acc ^ (raw_sr[NUM_ROWS-1] ? shift_row : 0)
  - raw_sr <= raw_sr<<1
  - cnt <= cnt+1
- ACC, on the edge accepting row NUM_ROWS (cnt==NUM_ROWS-1 & sum_en): hash_out <= final acc value (including that row), hash_valid<=1, go to DONE.
- Latency: the first row is expected the cycle after seed_ack. hash_valid rises the cycle after the last row. A full block is NUM_ROWS+1 cycles from the seed_ack cycle to hash_valid.
- ACC with sum_en=0:
  - If cnt==0: wait, no error.
  - If 0<cnt<NUM_ROWS: short block. Pulse row_err, discard acc, go to IDLE, hash_valid stays 0.
- sum_en=1 in IDLE, REQ or DONE: the row is ignored and row_err pulses for one cycle. State is unaffected.
- seed_ack outside REQ is ignored.
- DONE:
  - hash_out and hash_valid hold until hash_ready=1.
  - On that edge: hash_valid<=0, go to IDLE. hash_out keeps its last value.
- raw_valid outside IDLE is ignored. The producer must hold raw_valid and raw_data until accepted.
- Simultaneous hash_ready and a new raw_valid: hash_ready is taken in DONE. The raw block is accepted the next cycle in IDLE, giving one bubble.

Decomposition:
- Shared package toeplitz_pkg holds:
  - ROW_W, NUM_ROWS, CNT_W defaults, shared with the seed shifter
  - state encoding localparams IDLE/REQ/ACC/DONE
- One natural sub-module, toeplitz_xor_acc: the ROW_W-wide register with ports clr, en, bit, row, acc_q, computing acc_q <= clr ? 0 : en&bit ? acc_q^row : acc_q.
- The FSM, counter and raw shift register stay in the top level.

Test Plan:
All scenarios use ROW_W=8, NUM_ROWS=16, CNT_W=5. The shifter model pulses seed_ack 1 cycle after shift_en, then drives 16 rows.
- raw=16'h8001, row0=8'hA5, row15=8'h3C, rows 1-14=8'hFF -> hash_out=8'h99, hash_valid exactly 17 cycles after the seed_ack cycle, row_err never asserted.
- raw=16'hFFFF, row k=8'h01<<(k%8) -> hash_out=8'h00. raw=16'h0000 with any rows -> 8'h00.
- Backpressure: hold hash_ready=0 for 10 cycles -> hash_out/hash_valid stable; raw_ready=0 throughout; second raw_valid not accepted until the cycle after hash_ready.
- sum_en drops after 7 rows -> row_err single pulse, FSM back to IDLE, no hash_valid, raw_ready=1 next cycle.
- Stray sum_en=1 in IDLE, plus seed_ack pulse in IDLE -> row_err pulse for sum_en only, state stays IDLE, shift_en=0.
- rst=1 for one cycle at row 9 -> next cycle shift_en=0, hash_valid=0, raw_ready=1. A following clean block gives the correct hash with no residue.
